// File: rtl/vga_timing_gen.sv
// VGA raster timing: prescaled pixel tick drives h/v counters; syncs, coordinates and strobes are registered.
// Outputs update 1 iClk after a tick; iEn low freezes the prescaler, counters and level outputs (no backpressure input).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 4,
  parameter int CNT_W    = 11,
  parameter int FC_W     = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  output logic             oPixEn,
  output logic             oHSync,
  output logic             oVSync,
  output logic             oActive,
  output logic [CNT_W-1:0] oX,
  output logic [CNT_W-1:0] oY,
  output logic             oLineStart,
  output logic             oFrameStart,
  output logic [FC_W-1:0]  oFrameCnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0]    P_LAST = PW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [PW-1:0]    pCnt;
  logic             tick;
  logic             hWrap;
  logic [CNT_W-1:0] hNext;
  logic [CNT_W-1:0] vNext;
  logic             frameNext;

  // oX/oY double as the h/v counter state; everything else is derived from their next values.
  always_comb begin
    tick      = iEn && (pCnt == P_LAST);
    hWrap     = (oX == H_LAST);
    hNext     = oX;
    vNext     = oY;
    if (tick) begin
      hNext = hWrap ? '0 : oX + 1'b1;
      if (hWrap) begin
        vNext = (oY == V_LAST) ? '0 : oY + 1'b1;
      end
    end
    frameNext = tick && (hNext == '0) && (vNext == '0);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pCnt        <= '0;
      oX          <= H_LAST;
      oY          <= V_LAST;
      oActive     <= 1'b0;
      oHSync      <= ~HS_POL;
      oVSync      <= ~VS_POL;
      oPixEn      <= 1'b0;
      oLineStart  <= 1'b0;
      oFrameStart <= 1'b0;
      oFrameCnt   <= '0;
    end else begin
      if (iEn) begin
        pCnt <= tick ? '0 : pCnt + 1'b1;
      end
      oX          <= hNext;
      oY          <= vNext;
      oActive     <= (hNext < H_ACT) && (vNext < V_ACT);
      oHSync      <= (hNext >= HS_BEG && hNext <= HS_END) ? HS_POL : ~HS_POL;
      oVSync      <= (vNext >= VS_BEG && vNext <= VS_END) ? VS_POL : ~VS_POL;
      oPixEn      <= tick;
      oLineStart  <= tick && (hNext == '0);
      oFrameStart <= frameNext;
      if (frameNext) begin
        oFrameCnt <= oFrameCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small config (CLK_DIV 2 and 1) cycle tables plus frame/line sequences,
// and the default 640x480 config for first-pixel latency and horizontal sync placement.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // small config, CLK_DIV=2
  logic rstS, enS, peS, hsS, vsS, actS, lsS, fsS;
  logic [10:0] xS, yS;
  logic [7:0]  fcS;
  // small config, CLK_DIV=1
  logic rstO, enO, peO, hsO, vsO, actO, lsO, fsO;
  logic [10:0] xO, yO;
  logic [7:0]  fcO;
  // default config
  logic rstD, enD, peD, hsD, vsD, actD, lsD, fsD;
  logic [10:0] xD, yD;
  logic [7:0]  fcD;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(2), .CNT_W(11), .FC_W(8)
  ) dutS (
    .iClk(clk), .iRst(rstS), .iEn(enS), .oPixEn(peS), .oHSync(hsS), .oVSync(vsS),
    .oActive(actS), .oX(xS), .oY(yS), .oLineStart(lsS), .oFrameStart(fsS), .oFrameCnt(fcS)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CNT_W(11), .FC_W(8)
  ) dutO (
    .iClk(clk), .iRst(rstO), .iEn(enO), .oPixEn(peO), .oHSync(hsO), .oVSync(vsO),
    .oActive(actO), .oX(xO), .oY(yO), .oLineStart(lsO), .oFrameStart(fsO), .oFrameCnt(fcO)
  );

  vga_timing_gen dutD (
    .iClk(clk), .iRst(rstD), .iEn(enD), .oPixEn(peD), .oHSync(hsD), .oVSync(vsD),
    .oActive(actD), .oX(xD), .oY(yD), .oLineStart(lsD), .oFrameStart(fsD), .oFrameCnt(fcD)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [10:0] x;
    logic [10:0] y;
    logic        a, hs, vs, pe, ls, fs;
    logic [7:0]  fc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input int x, input int y,
                     input logic a, input logic hs, input logic vs,
                     input logic pe, input logic ls, input logic fs, input int fc);
    vec_t v;
    v.rst = rst; v.en = en; v.x = 11'(x); v.y = 11'(y);
    v.a = a; v.hs = hs; v.vs = vs; v.pe = pe; v.ls = ls; v.fs = fs; v.fc = 8'(fc);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstS = 1'b1; enS = 1'b0;
    rstO = 1'b1; enO = 1'b0;
    rstD = 1'b1; enD = 1'b0;

    // rst en  x y  act hs vs  pe ls fs  fc
    add(1, 1, 7, 5, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 7, 5, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 2, 0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) add(0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 3, 0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 5, 0, 0, 1, 0, 1, 0, 0, 1);
    add(0, 1, 5, 0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 6, 0, 0, 1, 0, 1, 0, 0, 1);
    add(0, 1, 6, 0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 7, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 2, 1, 1, 0, 0, 1, 0, 0, 1);
    add(1, 1, 7, 5, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 7, 5, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1);
    add(1, 0, 7, 5, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      rstS = vecs[i].rst;
      enS  = vecs[i].en;
      tick1();
      check($sformatf("vec%0d", i),
            64'({xS, yS, actS, hsS, vsS, peS, lsS, fsS, fcS}),
            64'({vecs[i].x, vecs[i].y, vecs[i].a, vecs[i].hs, vecs[i].vs,
                 vecs[i].pe, vecs[i].ls, vecs[i].fs, vecs[i].fc}));
    end

    // Small config, 256 frames: periods, sync placement, frame counter wrap.
    begin
      int frames = 0, lastFs = -1, lastLs = -1;
      int hsErr = 0, vsErr = 0, perErr = 0, lineErr = 0, fcErr = 0;
      logic [7:0] fc255 = 8'hxx, fc256 = 8'hxx;
      rstS = 1'b0; enS = 1'b1;
      for (int c = 0; c < 256 * 96 + 50 && frames < 256; c++) begin
        tick1();
        if (hsS !== (xS == 11'd5 || xS == 11'd6)) hsErr++;
        if (vsS !== (yS == 11'd4)) vsErr++;
        if (lsS) begin
          if (lastLs >= 0 && c - lastLs != 16) lineErr++;
          lastLs = c;
        end
        if (fsS) begin
          frames++;
          if (lastFs >= 0 && c - lastFs != 96) perErr++;
          lastFs = c;
          if (fcS !== 8'(frames)) fcErr++;
          if (frames == 255) fc255 = fcS;
          if (frames == 256) fc256 = fcS;
        end
      end
      check("s_frames_seen", 64'(frames), 64'd256);
      check("s_hsync_errs", 64'(hsErr), 64'd0);
      check("s_vsync_errs", 64'(vsErr), 64'd0);
      check("s_frame_period_errs", 64'(perErr), 64'd0);
      check("s_line_period_errs", 64'(lineErr), 64'd0);
      check("s_framecnt_errs", 64'(fcErr), 64'd0);
      check("s_fc_at_255", 64'(fc255), 64'd255);
      check("s_fc_wrap_256", 64'(fc256), 64'd0);
    end

    // CLK_DIV=1: continuous pixel enable, one pixel per edge, 8-cycle lines.
    begin
      int peErr = 0, xErr = 0, lsErr = 0, lastLs = -1;
      logic [10:0] prevX;
      enO = 1'b1;
      tick1();
      rstO = 1'b0;
      tick1();
      check("o_first_pixel", 64'({xO, yO, peO, lsO, fsO, fcO}), 64'({11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 8'd1}));
      prevX = xO;
      for (int c = 0; c < 40; c++) begin
        tick1();
        if (peO !== 1'b1) peErr++;
        if (xO !== 11'((prevX + 11'd1) % 11'd8)) xErr++;
        if (lsO !== (xO == 11'd0)) lsErr++;
        if (lsO) begin
          if (lastLs >= 0 && c - lastLs != 8) lsErr++;
          lastLs = c;
        end
        prevX = xO;
      end
      check("o_pixen_errs", 64'(peErr), 64'd0);
      check("o_x_step_errs", 64'(xErr), 64'd0);
      check("o_line_errs", 64'(lsErr), 64'd0);
      enO = 1'b0;
      tick1();
      check("o_disable_hold", 64'({peO, xO}), 64'({1'b0, prevX}));
    end

    // Default config: first pixel on the 4th edge, active/hsync placement on line 0.
    begin
      int n = 0, lowCnt = 0, vsErr = 0;
      bit inLow = 0, done = 0, gotPe = 0;
      logic [10:0] lowStartX = '1, endX = '1;
      logic lowStartPe = 1'b0, act639 = 1'bx, act640 = 1'bx;
      enD = 1'b1;
      tick1();
      rstD = 1'b0;
      for (int c = 1; c <= 10 && !gotPe; c++) begin
        tick1();
        n = c;
        gotPe = peD;
      end
      check("d_first_pe_edge", 64'(gotPe ? n : -1), 64'd4);
      check("d_first_pixel", 64'({xD, yD, fsD, fcD, actD, hsD, vsD}),
            64'({11'd0, 11'd0, 1'b1, 8'd1, 1'b1, 1'b1, 1'b1}));
      for (int c = 0; c < 4000 && !done; c++) begin
        tick1();
        if (vsD !== 1'b1) vsErr++;
        if (peD && xD == 11'd639) act639 = actD;
        if (peD && xD == 11'd640) act640 = actD;
        if (!inLow && !hsD) begin
          inLow = 1; lowStartX = xD; lowStartPe = peD;
        end
        if (inLow && !hsD) lowCnt++;
        if (inLow && hsD) begin
          done = 1; endX = xD;
        end
      end
      check("d_hsync_done", 64'(done), 64'd1);
      check("d_hsync_start_x", 64'({lowStartPe, lowStartX}), 64'({1'b1, 11'd656}));
      check("d_hsync_low_cycles", 64'(lowCnt), 64'd384);
      check("d_hsync_end_x", 64'(endX), 64'd752);
      check("d_active_639", 64'(act639), 64'd1);
      check("d_active_640", 64'(act640), 64'd0);
      check("d_vsync_line0_errs", 64'(vsErr), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It is the next-generation core under `VGA_Top` and replaces fixed 640x480 timing with configurable porch, sync and active widths, sync polarities and a pixel-clock prescaler. It drives `oHSync`/`oVSync` to the connector and provides pixel coordinates, an active-video flag and frame/line strobes to the pixel/RGB generator.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels, ≥1)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines, ≥1)
- `HS_POL`, 0, asserted level of `oHSync`
- `VS_POL`, 0, asserted level of `oVSync`
- `CLK_DIV`, 4, `iClk` cycles per pixel (≥1)
- `CNT_W`, 11, coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W
- `FC_W`, 8, frame counter width
- `iClk`  in  1  system clock; sole clock
- `iRst`  in  1  reset, synchronous, active-high
- `iEn`  in  1  run enable; low freezes all timing
- `oPixEn`  out  1  one-`iClk` strobe: first cycle a new pixel's outputs are valid
- `oHSync`  out  1  horizontal sync
- `oVSync`  out  1  vertical sync
- `oActive`  out  1  current pixel is inside the visible area
- `oX`  out  CNT_W  horizontal count, 0..H_TOTAL-1
- `oY`  out  CNT_W  vertical count, 0..V_TOTAL-1
- `oLineStart`  out  1  strobe with `oPixEn` when `oX` becomes 0
- `oFrameStart`  out  1  strobe with `oPixEn` when (`oX`,`oY`) becomes (0,0)
- `oFrameCnt`  out  FC_W  completed-frame-start count, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way from the vertical parameters.
- Prescaler p counts 0..CLK_DIV-1 while `iEn`=1, and holds while `iEn`=0. A tick occurs when `iEn`=1 and p=CLK_DIV-1; the next p is 0.
- On a tick, hcnt advances and wraps from H_TOTAL-1 to 0. On that wrap, vcnt advances and wraps from V_TOTAL-1 to 0.
- All outputs are registers computed from next-state counters, so they update on the same edge as hcnt/vcnt.
  - `oX`=hcnt, `oY`=vcnt.
  - `oActive` = (hcnt<H_ACTIVE) and (vcnt<V_ACTIVE).
  - `oHSync`=HS_POL when hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise it is ~HS_POL.
  - `oVSync`=VS_POL when vcnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; otherwise it is ~VS_POL. `oVSync` is a function of vcnt only and changes at line boundaries.
  - `oPixEn` is the registered tick. `oLineStart` = tick and next hcnt=0. `oFrameStart` = tick and next (hcnt,vcnt)=(0,0).
  - `oFrameCnt` increments (mod 2^FC_W) on the edge that asserts `oFrameStart`.
- Reset state:
  - p=0, hcnt=H_TOTAL-1, vcnt=V_TOTAL-1.
  - `oX`=H_TOTAL-1, `oY`=V_TOTAL-1.
  - `oActive`=0, `oHSync`=~HS_POL, `oVSync`=~VS_POL.
  - `oPixEn`=`oLineStart`=`oFrameStart`=0, `oFrameCnt`=0.
  - Consequence: the first tick after reset presents pixel (0,0) with `oFrameStart`=1 and `oFrameCnt`=1.
- `iRst` has priority over `iEn`. Reset asserted mid-frame or mid-pixel returns to the reset state on the next edge.
- `iEn` deasserted mid-pixel: p, counters and level outputs hold; strobes are 0. Resuming continues from the held p, so no pixel is shortened or repeated.
- CLK_DIV=1: the tick equals `iEn`, and `oPixEn` is continuously high while enabled.

## Timing
- Latency: 1 `iClk` from a tick to the new outputs (`oPixEn`=1 in that cycle).
- Pixel period is CLK_DIV `iClk`; the strobes are exactly 1 `iClk` wide for any CLK_DIV.
- Line period is H_TOTAL·CLK_DIV `iClk`; frame period is H_TOTAL·V_TOTAL·CLK_DIV `iClk`.
- Defaults at 100 MHz `iClk`: 25 MHz pixel clock, 800x525 total, frame = 1,680,000 `iClk`.
- No combinational path from any input to any output.

## Test plan
- Reset with `iEn`=1, defaults: after release, first `oPixEn` on the 4th edge with `oX`=0, `oY`=0, `oFrameStart`=1, `oFrameCnt`=1, `oActive`=1. Next `oFrameStart` comes exactly 1,680,000 `iClk` later with `oFrameCnt`=2.
- Default horizontal timing: `oHSync` is low for exactly 96·4=384 `iClk`, starting with the strobe where `oX`=656. `oActive` falls at `oX`=640. `oVSync` is low only while `oY` is 490 or 491.
- Small config (H 4/1/2/1, V 3/1/1/1, CLK_DIV 2, HS_POL=VS_POL=1): line = 16 `iClk`; `oHSync` high for `oX`=5,6; `oVSync` high on `oY`=4; frame = 96 `iClk`; `oFrameCnt` wraps 255→0 on the 256th frame (with FC_W=8).
- `iEn` toggled low for 7 `iClk` at p=1 in the small config: outputs hold and no strobes occur; the pixel completes after 1 more enabled `iClk`; all later strobes are shifted by exactly 7 cycles.
- `iRst` asserted mid-active line (`oX`=2, `oY`=1): next edge shows `oX`=7, `oY`=5, syncs inactive, `oFrameCnt`=0; restart reproduces the first scenario.
- CLK_DIV=1, small config: `oPixEn` is constantly 1 while `iEn`=1; `oX` increments every edge; line = 8 `iClk`.
